dmem_lsu: RTL and testbench

DMEM_LSU -- requirements
Module: dmem_lsu

---
 rtl/dmem_lsu.sv | 147 ++++++++++++++
 tb/tb_dmem_lsu.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Load/store unit bridging an RV32I core to a single-port word-wide data memory.
// Optional LSU_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module dmem_lsu #(
    parameter int DATA_WIDTH_LENGTH = 32,
    parameter int ADDR_WIDTH_LENGTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [2:0]                   req_funct3,
    input  logic [ADDR_WIDTH_LENGTH-1:0] req_addr,
    input  logic [DATA_WIDTH_LENGTH-1:0] req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_WIDTH_LENGTH-1:0] rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_WIDTH_LENGTH-1:0] mem_addr,
    output logic [DATA_WIDTH_LENGTH-1:0] mem_wdata,
    output logic                         mem_rw,
    input  logic [DATA_WIDTH_LENGTH-1:0] mem_rdata
);

    typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, RESP} state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        illegal, misalign, req_err;

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] a);
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = w >> {a, 3'b000};
        b  = sh[7:0];
        h  = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'b0, b};
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b101:  load_ext = {16'b0, h};
            default: load_ext = w;
        endcase
    endfunction

    // Sub-word store: overwrite only the addressed lane of the word just read.
    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [15:0] d,
                                                input logic f3_half, input logic [1:0] a);
        logic [31:0] mask;
        if (f3_half) begin
            store_merge = a[1] ? {d, w[15:0]} : {w[31:16], d};
        end else begin
            mask        = 32'h0000_00FF << {a, 3'b000};
            store_merge = (w & ~mask) | ({24'b0, d[7:0]} << {a, 3'b000});
        end
    endfunction

    always_comb begin
        illegal  = 1'b0;
        misalign = 1'b0;
        if (req_we)
            illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        else
            illegal = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));
`endif
        req_err = illegal | misalign;
    end

    assign req_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            f3_q      <= 3'b0;
            lane_q    <= 2'b0;
            wdata_q   <= 16'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        f3_q     <= req_funct3;
                        lane_q   <= req_addr[1:0];
                        wdata_q  <= req_wdata[15:0];
                        mem_addr <= {req_addr[ADDR_WIDTH_LENGTH-1:2], 2'b00};
                        if (req_err) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else if (req_we && req_funct3[1:0] == 2'b10) begin
                            mem_wdata <= req_wdata;
                            mem_rw    <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    if (!we_q) begin
                        rsp_rdata <= load_ext(mem_rdata, f3_q, lane_q);
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        mem_wdata <= store_merge(mem_rdata, wdata_q, f3_q[0], lane_q);
                        mem_rw    <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    mem_rw    <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a one-cycle-latency word memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rw;

    logic [31:0] mem [0:255];
    logic        preload;
    int          wr_total;
    logic [31:0] wr_addr, wr_data;

    int checks = 0;
    int errors = 0;
    int lat, wr_lat, n_wr;

    always #5 clk = ~clk;

    dmem_lsu #(.DATA_WIDTH_LENGTH(32), .ADDR_WIDTH_LENGTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            mem[8'h40] <= 32'h8899AABB;
        end else if (mem_rw) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_total <= wr_total + 1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end else if (wr_total < 0) begin
            wr_total <= 0;
        end
        mem_rdata <= mem[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for rsp_valid; lat counts cycles from acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int w0;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        w0 = wr_total;
        lat = 1; wr_lat = 0;
        forever begin
            @(negedge clk);
            if (mem_rw) wr_lat = lat;
            if (rsp_valid || lat >= 20) break;
            @(posedge clk);
            lat++;
        end
        n_wr = wr_total - w0;
    endtask

    task automatic respond(input string tag);
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk({tag, "_rsp_drop"}, {31'b0, rsp_valid}, 32'h0);
    endtask

    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] exp);
        issue(1'b0, f3, addr, 32'h0);
        chk({tag, "_lat"}, lat, 3);
        chk({tag, "_rdata"}, rsp_rdata, exp);
        chk({tag, "_err"}, {31'b0, rsp_err}, 32'h0);
        chk({tag, "_nowr"}, n_wr, 0);
        respond(tag);
    endtask

    initial begin
        rst_n = 1'b0; preload = 1'b1; wr_total = 0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0;
        #2;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_mem_rw",    {31'b0, mem_rw},    32'h0);
        chk("rst_mem_addr",  mem_addr,  32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata",     rsp_rdata, 32'h0);
        chk("rst_err",       {31'b0, rsp_err}, 32'h0);
        @(posedge clk); #1 preload = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        load("lb_101",  3'b000, 32'h101, 32'hFFFFFFAA);
        load("lbu_101", 3'b100, 32'h101, 32'h000000AA);
        load("lb_100",  3'b000, 32'h100, 32'hFFFFFFBB);
        load("lb_103",  3'b000, 32'h103, 32'hFFFFFF88);
        load("lhu_102", 3'b101, 32'h102, 32'h00008899);
        load("lh_102",  3'b001, 32'h102, 32'hFFFF8899);
        load("lw_100",  3'b010, 32'h100, 32'h8899AABB);

        issue(1'b1, 3'b000, 32'h103, 32'h00000012);
        chk("sb_lat", lat, 4);
        chk("sb_wr_lat", wr_lat, 3);
        chk("sb_nwr", n_wr, 1);
        chk("sb_wr_addr", wr_addr, 32'h100);
        chk("sb_wr_data", wr_data, 32'h1299AABB);
        chk("sb_rdata", rsp_rdata, 32'h0);
        respond("sb");
        load("lw_after_sb", 3'b010, 32'h100, 32'h1299AABB);

        issue(1'b1, 3'b001, 32'h102, 32'hABCD5678);
        chk("sh_lat", lat, 4);
        chk("sh_wr_data", wr_data, 32'h5678AABB);
        respond("sh");
        load("lw_after_sh", 3'b010, 32'h100, 32'h5678AABB);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 32'h101, 32'h0);
        chk("lh_mis_lat", lat, 1);
        chk("lh_mis_err", {31'b0, rsp_err}, 32'h1);
        chk("lh_mis_nowr", wr_lat, 0);
        respond("lh_mis");
        issue(1'b1, 3'b010, 32'h102, 32'h11111111);
        chk("sw_mis_err", {31'b0, rsp_err}, 32'h1);
        chk("sw_mis_nowr", n_wr, 0);
        respond("sw_mis");
`else
        load("lh_mis", 3'b001, 32'h101, 32'hFFFFAABB);
`endif

        issue(1'b0, 3'b011, 32'h100, 32'h0);
        chk("ld011_lat", lat, 1);
        chk("ld011_err", {31'b0, rsp_err}, 32'h1);
        chk("ld011_rdata", rsp_rdata, 32'h0);
        respond("ld011");
        issue(1'b1, 3'b100, 32'h100, 32'hFFFFFFFF);
        chk("st100_lat", lat, 1);
        chk("st100_err", {31'b0, rsp_err}, 32'h1);
        chk("st100_nowr", n_wr + wr_lat, 0);
        respond("st100");

        issue(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_lat", lat, 2);
        chk("sw_wr_lat", wr_lat, 1);
        chk("sw_nwr", n_wr, 1);
        chk("sw_wr_data", wr_data, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("sw_stall_valid", {31'b0, rsp_valid}, 32'h1);
            chk("sw_stall_rdata", rsp_rdata, 32'h0);
            chk("sw_stall_ready", {31'b0, req_ready}, 32'h0);
        end
        respond("sw");

        // SH aborted by reset while in READ
        begin
            int w0;
            @(negedge clk);
            req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h100; req_wdata = 32'h4444;
            req_valid = 1'b1;
            @(posedge clk);
            #1 req_valid = 1'b0;
            w0 = wr_total;
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_req_ready", {31'b0, req_ready}, 32'h1);
            chk("abort_mem_addr", mem_addr, 32'h0);
            chk("abort_mem_rw", {31'b0, mem_rw}, 32'h0);
            #2 rst_n = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                if (mem_rw) wr_lat = 99;
            end
            chk("abort_nowr", wr_total - w0, 0);
            chk("abort_idle", {31'b0, req_ready}, 32'h1);
            chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        end
        load("lw_after_abort", 3'b010, 32'h100, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
